// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: finds the TMDS symbol boundary from control-token runs and decodes
// each aligned symbol to video data or control data for one channel.
module tmds_channel_decoder #(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_LEN = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    output logic [7:0] data,
    output logic       de,
    output logic [1:0] cd,
    output logic       locked,
    output logic [3:0] bit_offset
);
    localparam int SW = $clog2(SEARCH_LEN);
    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    localparam logic [SW-1:0] SCNT_END = SW'(SEARCH_LEN - 1);
    localparam logic [7:0] RUN_END = 8'(CTRL_RUN - 1);

    logic [0:0] state, state_n;
    logic [9:0] prev, win;
    logic [7:0] q, d, run, run_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [3:0] off_n;
    logic [1:0] tok;
    logic is_ctrl, lock_hit, slip, lose, stay;

    always_comb begin
        win = 10'({sym_in, prev} >> bit_offset);
        tok = win == 10'b0010101011 ? 2'b01 :
              win == 10'b0101010100 ? 2'b10 :
              win == 10'b1010101011 ? 2'b11 : 2'b00;
        is_ctrl = tok != 2'b00 || win == 10'b1101010100;
        q = win[9] ? ~win[7:0] : win[7:0];
        d = {q[7:1] ^ q[6:0] ^ {7{~win[8]}}, q[0]};
        // a lock and a slip due in the same cycle resolve in favour of the lock
        lock_hit = state == SEARCH && is_ctrl && run >= RUN_END;
        slip = state == SEARCH && !lock_hit && scnt == SCNT_END;
        lose = state == LOCKED && !is_ctrl && scnt == SCNT_END;
        stay = state == LOCKED ? !lose : lock_hit;
        state_n = stay ? LOCKED : SEARCH;
        run_n = (state == LOCKED || !is_ctrl || lock_hit || slip) ? 8'd0 : run + {7'd0, run != 8'hFF};
        scnt_n = (lock_hit || slip || lose || (state == LOCKED && is_ctrl)) ? '0 :
                 scnt + {{(SW-1){1'b0}}, scnt != '1};
        off_n = !slip ? bit_offset : bit_offset == 4'd9 ? 4'd0 : bit_offset + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            state <= SEARCH;
            run <= '0;
            scnt <= '0;
            bit_offset <= '0;
            locked <= 1'b0;
            de <= 1'b0;
            data <= '0;
            cd <= '0;
        end else begin
            prev <= sym_in;
            state <= state_n;
            run <= run_n;
            scnt <= scnt_n;
            bit_offset <= off_n;
            locked <= state_n == LOCKED;
            de <= state_n == LOCKED && !is_ctrl;
            data <= (state_n == LOCKED && !is_ctrl) ? d : 8'h00;
            cd <= state_n != LOCKED ? 2'b00 : is_ctrl ? tok : cd;
        end
    end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed bench with an independent TMDS encoder model driving
// aligned and bit-rotated streams into the decoder.
module tb_tmds_channel_decoder;
    logic clk = 1'b0;
    logic rst;
    logic [9:0] sym_in;
    logic [7:0] data;
    logic de;
    logic [1:0] cd;
    logic locked;
    logic [3:0] bit_offset;

    int cmps = 0, errs = 0, disp = 0, k_mis = 0, w = 0;
    logic [9:0] prev_sym;
    logic chk_on;
    logic pe_de, oe_de;
    logic [7:0] pe_data, oe_data;
    logic [1:0] pe_cd, oe_cd, last_cd;
    logic [3:0] old_off;

    tmds_channel_decoder dut (
        .clk(clk), .rst(rst), .sym_in(sym_in), .data(data), .de(de),
        .cd(cd), .locked(locked), .bit_offset(bit_offset)
    );

    always #5 clk = ~clk;

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] enc(input logic [7:0] b);
        logic [8:0] qm;
        logic [9:0] r;
        logic use_xnor;
        int n1q, n0q;
        use_xnor = $countones(b) > 4 || ($countones(b) == 4 && !b[0]);
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
        qm[8] = !use_xnor;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp = qm[8] ? disp + n1q - n0q : disp + n0q - n1q;
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            r = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            r = {1'b0, qm[8], qm[7:0]};
            disp = disp - (qm[8] ? 0 : 2) + n1q - n0q;
        end
        return r;
    endfunction

    function automatic logic [9:0] token(input logic [1:0] c);
        return c == 2'b00 ? 10'b1101010100 : c == 2'b01 ? 10'b0010101011 :
               c == 2'b10 ? 10'b0101010100 : 10'b1010101011;
    endfunction

    // The symbol sent in one call is visible on the outputs after the following call.
    task automatic send(input logic [9:0] s, input logic e_de, input logic [7:0] e_d, input logic [1:0] e_cd);
        logic [19:0] t;
        t = {s, prev_sym} >> (10 - k_mis);
        sym_in = t[9:0];
        prev_sym = s;
        @(posedge clk);
        #1;
        oe_de = pe_de;
        oe_data = pe_data;
        oe_cd = pe_cd;
        pe_de = e_de;
        pe_data = e_de ? e_d : 8'h00;
        pe_cd = e_cd;
        if (chk_on) begin
            ck("de", de, oe_de);
            ck("data", data, oe_data);
            ck("cd", cd, oe_cd);
        end
    endtask

    task automatic send_c(input logic [1:0] c);
        disp = 0;
        last_cd = c;
        send(token(c), 1'b0, 8'h00, c);
    endtask

    task automatic send_d(input logic [7:0] b);
        send(enc(b), 1'b1, b, last_cd);
    endtask

    task automatic send_line();
        if (w % 1650 < 370) send_c(2'b00);
        else send_d(8'(w * 37 + 11));
        w++;
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        sym_in = '0;
        prev_sym = '0;
        k_mis = k;
        disp = 0;
        w = 0;
        chk_on = 1'b0;
        last_cd = 2'b00;
        {pe_de, pe_data, pe_cd, oe_de, oe_data, oe_cd} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sym_in = '0;
        @(posedge clk);
        #1;
        ck("rst_data", data, 0);
        ck("rst_de", de, 0);
        ck("rst_cd", cd, 0);
        ck("rst_locked", locked, 0);
        ck("rst_offset", bit_offset, 0);
        do_reset(0);

        for (int i = 1; i <= 100; i++) begin
            send_c(2'b00);
            if (i == 8) ck("no_lock_7", locked, 0);
            if (i == 9) begin
                ck("lock_8th", locked, 1);
                ck("lock_de", de, 0);
                chk_on = 1'b1;
            end
        end
        send_d(8'h00);
        send_d(8'hFF);
        send_d(8'h10);
        send_d(8'hA5);
        send_c(2'b00);
        ck("aligned_offset", bit_offset, 0);

        for (int c = 1; c < 4; c++) begin
            send_c(2'(c));
            send_c(2'(c));
            send_d(8'(c * 50 + 3));
        end
        send_c(2'b00);
        send_c(2'b00);

        for (int i = 0; i < 2048; i++) send_d(8'(i * 13 + 1));
        ck("loss_before", locked, 1);
        chk_on = 1'b0;
        send_d(8'h77);
        ck("loss_locked", locked, 0);
        ck("loss_de", de, 0);
        ck("loss_data", data, 0);
        ck("loss_offset", bit_offset, 0);
        for (int i = 1; i <= 9; i++) begin
            send_c(2'b00);
            if (i == 8) ck("relock_early", locked, 0);
        end
        ck("relock", locked, 1);
        ck("relock_offset", bit_offset, 0);

        chk_on = 1'b1;
        send_d(8'h3C);
        send_d(8'h3C);
        ck("pre_rst_de", de, 1);
        #3 rst = 1'b1;
        #1;
        ck("async_data", data, 0);
        ck("async_de", de, 0);
        ck("async_locked", locked, 0);
        ck("async_cd", cd, 0);
        do_reset(0);
        ck("post_rst_offset", bit_offset, 0);

        for (int i = 0; i < 7; i++) send_c(2'b00);
        for (int i = 0; i < 20; i++) begin
            send_d(8'(i * 9));
            ck("run7_nolock", locked, 0);
        end

        do_reset(3);
        for (int n = 0; n < 12000 && !locked; n++) begin
            old_off = bit_offset;
            send_line();
            if (bit_offset != old_off) ck("slip_step3", bit_offset, 4'(old_off + 1));
        end
        ck("lock3", locked, 1);
        ck("offset3", bit_offset, 3);
        chk_on = 1'b1;
        for (int n = 0; n < 3300; n++) send_line();
        chk_on = 1'b0;
        ck("offset3_kept", bit_offset, 3);

        do_reset(9);
        for (int n = 0; n < 25000 && !locked; n++) send_line();
        ck("lock9", locked, 1);
        ck("offset9", bit_offset, 9);
        for (int n = 0; n < 5000 && bit_offset == 4'd9; n++) send_d(8'(n * 5 + 2));
        ck("wrap_offset", bit_offset, 0);
        ck("wrap_locked", locked, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the per-channel TMDS encoder. Takes the raw 10-bit words from a deserializer, which may be misaligned to the symbol boundary, and finds the boundary by searching for runs of control tokens. Once aligned it decodes each symbol back to 8-bit video data or 2-bit control data plus a data-enable flag. One instance per TMDS channel (red, green, blue), clocked by the recovered pixel clock.

## Interface
Parameters:
- `CTRL_RUN`, default 8: consecutive control tokens at one offset required to declare lock (range 2..255).
- `SEARCH_LEN`, default 2048: words allowed without a qualifying token run before slipping offset (SEARCH), or without any token before losing lock (LOCKED). Must exceed one line (1650); range 16..4095.

Ports:
- `clk` in 1: pixel clock; one deserialized word per cycle.
- `rst` in 1: asynchronous, active-high reset.
- `sym_in` in 10: raw word; bit 0 = first bit received on the wire (the encoder serializes LSB first).
- `data` out 8: decoded video byte.
- `de` out 1: 1 = `data` valid (video period); 0 = control period.
- `cd` out 2: decoded control data ({vSync,hSync} on the blue channel).
- `locked` out 1: alignment achieved.
- `bit_offset` out 4: current alignment offset, 0..9.

## Operation
- Window: `cat = {sym_in, prev}`, where `prev` is `sym_in` registered every cycle (reset 0). `win = cat[bit_offset+9 : bit_offset]`.
- Control tokens (`win[9:0]` MSB first):
  - 1101010100 → cd=00
  - 0010101011 → cd=01
  - 0101010100 → cd=10
  - 1010101011 → cd=11
  - `is_ctrl` = `win` equals any of the four.
- Data decode for a non-token `win`:
  - q = win[9] ? ~win[7:0] : win[7:0].
  - d[0] = q[0].
  - For i = 1..7: d[i] = q[i] ^ q[i-1] ^ ~win[8].
  - This is the exact inverse of the encoder's XOR/XNOR stage, including the case where bit 9 inverts the word.
- State machine, two states, reset to SEARCH:
  - SEARCH:
    - `run` counts consecutive `is_ctrl` windows and clears on any non-token.
    - `scnt` counts every cycle.
    - `run` reaching CTRL_RUN → LOCKED; clear `run` and `scnt`.
    - Otherwise `scnt` reaching SEARCH_LEN−1 → `bit_offset` = (`bit_offset`==9) ? 0 : `bit_offset`+1; clear `run` and `scnt`.
    - If both conditions occur in the same cycle, lock wins and the offset is not slipped.
  - LOCKED:
    - `scnt` counts consecutive non-token windows and clears on any token.
    - `scnt` reaching SEARCH_LEN−1 → SEARCH; `bit_offset` unchanged; counters cleared.
- Output register (updated every cycle):
  - LOCKED and `is_ctrl`: de=0, cd=token value, data=0.
  - LOCKED and not `is_ctrl`: de=1, data=d, cd unchanged.
  - SEARCH: de=0, cd=00, data=0.
- `locked` is a registered copy of state==LOCKED. `bit_offset` is the register itself.
- Counter widths: `run` is 8 bits; `scnt` is ceil(log2(SEARCH_LEN)) bits. Both saturate and never wrap.

## Timing
- Reset values: data=0, de=0, cd=00, locked=0, bit_offset=0, prev=0, state=SEARCH, counters 0. Reset asserted mid-stream takes effect immediately, whether searching or locked.
- Latency: the symbol whose first bit sits at `sym_in[k]` in cycle N (aligned offset k) appears on `data`/`de`/`cd` after the rising edge at the end of cycle N+1. This is 2 edges from sampling, constant for all offsets.
- `locked` rises on the same edge as the first decoded output (the CTRL_RUN-th token). Outputs are forced to de=0 from that edge only if the state is SEARCH.
- An offset slip takes effect on the next cycle's window. One slip occurs per SEARCH_LEN cycles, so worst-case acquisition is 10·SEARCH_LEN + CTRL_RUN cycles.
- Lock loss: `locked` falls SEARCH_LEN cycles after the last token. Output drops to de=0 on the same edge.
- No backpressure: the input is continuous and the block never stalls.

## Test plan
- Aligned stream: encoder output with 100 tokens cd=00, then data 0x00, 0xFF, 0x10, 0xA5 → locked=1 on the 8th token. The bytes then decode exactly in order with de=1, 2-cycle latency, bit_offset=0.
- Misaligned by 3 bits: the same stream rotated by 3 across word boundaries, with 1650-word lines of 370 tokens → bit_offset steps 0,1,2,3, then locks. All subsequent bytes match, with zero mismatches over 2 lines.
- Control decode on blue: tokens for {vSync,hSync} = 00, 01, 10, 11 → cd follows with de=0. Also check a token run of exactly 7 then data: lock is not achieved.
- Lock loss: after lock, feed 2048 consecutive data words → locked falls on the 2048th word; bit_offset is retained; a new token run re-locks at the same offset.
- Offset wrap: start misaligned by 9 with default params → offset reaches 9 and locks. Separately, force a mismatch so the offset advances past 9 to 0.
- Async reset mid-lock: assert `rst` between edges → all outputs go to 0 immediately. After release, reacquisition starts from offset 0.
